led_flash_sched: RTL

- Multi-channel LED blink scheduler for front-panel status LEDs.
- Generates one shared tick time base from clk.
- Each channel runs its own small FSM to produce OFF, steady ON, continuous blink, or N-flash burst patterns.
- Per-channel configuration arrives over a simple write port from the sequencing logic, so one block serves all LEDs instead of one free-running flasher per LED.

---
 rtl/led_sched_pkg.sv | 27 ++
 rtl/led_chan_fsm.sv | 144 ++++++++++++++
 rtl/led_flash_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED flash scheduler: mode encoding, channel
// state encoding and default widths. The optional LED_SYNC_EN build adds
// the SYNC channel state.
package led_sched_pkg;

    localparam int unsigned DEF_NCH         = 4;
    localparam int unsigned DEF_CW          = 16;
    localparam int unsigned DEF_PRESCALE    = 1024;
    localparam int unsigned DEF_BW          = 8;
    localparam int unsigned DEF_SYNC_PERIOD = 4096;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_BURST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEADY = 2'd1,
        ST_RUN    = 2'd2
`ifdef LED_SYNC_EN
        ,
        ST_SYNC   = 2'd3
`endif
    } chan_state_e;

endpackage

// File: rtl/led_chan_fsm.sv
// One LED channel: latched config, phase counter, remaining-burst counter,
// state machine and registered led/busy/done outputs.
// Macro LED_SYNC_EN adds sync_i and a SYNC state that waits for the frame wrap.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   we_i               config write for this channel
//   mode_i/on_i/period_i/count_i  config payload
//   tick_i             shared time-base tick
//   sync_i             frame-wrap pulse (LED_SYNC_EN only)
//   led_o, busy_o, done_o  registered channel outputs
module led_chan_fsm
    import led_sched_pkg::*;
#(
    parameter int unsigned CW = DEF_CW,
    parameter int unsigned BW = DEF_BW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [1:0]    mode_i,
    input  logic [CW-1:0] on_i,
    input  logic [CW-1:0] period_i,
    input  logic [BW-1:0] count_i,
    input  logic          tick_i,
`ifdef LED_SYNC_EN
    input  logic          sync_i,
`endif
    output logic          led_o,
    output logic          busy_o,
    output logic          done_o
);

    chan_state_e   state_q;
    logic [CW-1:0] t_q;
    logic [CW-1:0] p_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] rem_q;
    logic          burst_q;
    logic          fin_q;
    logic          led_q;
    logic          busy_q;
    logic          done_q;
    logic          led_c;
    logic          busy_c;

    // Output decode from the current state; registered below, so outputs
    // trail the state/counter update by one clk.
    always_comb begin
        led_c  = 1'b0;
        busy_c = 1'b0;
        case (state_q)
            ST_STEADY: led_c = 1'b1;
            ST_RUN: begin
                led_c  = (cnt_q < t_q);
                busy_c = 1'b1;
            end
`ifdef LED_SYNC_EN
            ST_SYNC: busy_c = 1'b1;
`endif
            default: ;
        endcase
    end

    // Channel state machine; a write always takes priority over a tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            burst_q <= 1'b0;
            fin_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fin_q  <= 1'b0;
            led_q  <= led_c;
            busy_q <= busy_c;
            // fin_q marks the burst-end state update; delaying it aligns
            // done with the clk where busy falls and led is forced low.
            done_q <= fin_q;
            if (we_i) begin
                t_q     <= on_i;
                p_q     <= (period_i == '0) ? CW'(1) : period_i;
                burst_q <= (mode_i == MODE_BURST);
                cnt_q   <= '0;
                rem_q   <= count_i;
                case (mode_i)
                    MODE_OFF: state_q <= ST_IDLE;
                    MODE_ON:  state_q <= ST_STEADY;
                    default: begin
                        if ((mode_i == MODE_BURST) && (count_i == '0)) begin
                            // Empty burst finishes without ever lighting.
                            state_q <= ST_IDLE;
                            fin_q   <= 1'b1;
                        end else begin
`ifdef LED_SYNC_EN
                            state_q <= ST_SYNC;
`else
                            state_q <= ST_RUN;
`endif
                        end
                    end
                endcase
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (tick_i) begin
                            if (cnt_q == (p_q - CW'(1))) begin
                                cnt_q <= '0;
                                if (burst_q) begin
                                    if (rem_q == BW'(1)) begin
                                        state_q <= ST_IDLE;
                                        fin_q   <= 1'b1;
                                    end else begin
                                        rem_q <= rem_q - BW'(1);
                                    end
                                end
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
`ifdef LED_SYNC_EN
                    ST_SYNC: begin
                        if (sync_i) begin
                            state_q <= ST_RUN;
                            cnt_q   <= '0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign led_o  = led_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/led_flash_sched.sv
// Multi-channel LED blink scheduler: shared tick prescaler, config write
// decode and NCH per-channel flash FSMs.
// Macro LED_SYNC_EN adds a global frame counter (SYNC_PERIOD ticks) that
// releases blinking channels together at each frame wrap.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   cfg_we_i, cfg_ch_i config write strobe and target channel (>= NCH ignored)
//   cfg_mode_i, cfg_on_i, cfg_period_i, cfg_count_i  config payload
//   tick_o             one-clk time-base pulse
//   led_o, busy_o, done_o  per-channel registered outputs
module led_flash_sched
    import led_sched_pkg::*;
#(
    parameter int unsigned NCH         = DEF_NCH,
    parameter int unsigned CW          = DEF_CW,
    parameter int unsigned PRESCALE    = DEF_PRESCALE,
    parameter int unsigned BW          = DEF_BW,
    parameter int unsigned SYNC_PERIOD = DEF_SYNC_PERIOD,
    localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cfg_we_i,
    input  logic [CHW-1:0] cfg_ch_i,
    input  logic [1:0]     cfg_mode_i,
    input  logic [CW-1:0]  cfg_on_i,
    input  logic [CW-1:0]  cfg_period_i,
    input  logic [BW-1:0]  cfg_count_i,
    output logic           tick_o,
    output logic [NCH-1:0] led_o,
    output logic [NCH-1:0] busy_o,
    output logic [NCH-1:0] done_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Elaboration-time parameter sanity check.
    if ((NCH < 1) || (NCH > 8) || (PRESCALE < 1) || (SYNC_PERIOD < 1)) begin : g_param_chk
        $error("led_flash_sched: parameter out of range");
    end

    logic [PW-1:0]  pre_q;
    logic [PW-1:0]  pre_d;
    logic           tick_q;
    logic [NCH-1:0] we_c;

    // Prescaler; tick is registered from the next count so it is high
    // exactly while the count sits at PRESCALE-1, and low in reset.
    always_comb begin
        pre_d = (pre_q == PW'(PRESCALE - 1)) ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == PW'(PRESCALE - 1));
        end
    end

    // Write decode; channel numbers with no matching instance select nothing.
    always_comb begin
        we_c = '0;
        for (int i = 0; i < NCH; i++) begin
            we_c[i] = cfg_we_i && (cfg_ch_i == CHW'(i));
        end
    end

`ifdef LED_SYNC_EN
    localparam int unsigned FW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;

    logic [FW-1:0] frame_q;
    logic          frame_wrap_c;

    assign frame_wrap_c = tick_q && (frame_q == FW'(SYNC_PERIOD - 1));

    // Global frame counter in ticks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_q <= '0;
        end else if (tick_q) begin
            frame_q <= frame_wrap_c ? '0 : frame_q + FW'(1);
        end
    end
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        led_chan_fsm #(
            .CW (CW),
            .BW (BW)
        ) u_chan (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .we_i     (we_c[g]),
            .mode_i   (cfg_mode_i),
            .on_i     (cfg_on_i),
            .period_i (cfg_period_i),
            .count_i  (cfg_count_i),
            .tick_i   (tick_q),
`ifdef LED_SYNC_EN
            .sync_i   (frame_wrap_c),
`endif
            .led_o    (led_o[g]),
            .busy_o   (busy_o[g]),
            .done_o   (done_o[g])
        );
    end

    assign tick_o = tick_q;

endmodule
